// File: rtl/led_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package led_pkg;

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low glyphs {A,B,C,D,E,F,G,DP}, DP left off; entry 0 is the LSB.
  localparam logic [15:0][7:0] GLYPH = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

endpackage

// File: rtl/led_hex_decode.sv
// {dp, hex} to active-low segment pattern {A..G, DP}.
module led_hex_decode
  import led_pkg::*;
(
  input  logic [4:0] digit,
  output logic [7:0] seg
);

  assign seg = GLYPH[digit[3:0]] & {7'h7F, ~digit[4]};

endmodule

// File: rtl/led_scan_ctrl.sv
// Multiplexed LED digit scanner with shadow/active buffers and frame-aligned commit.
// Optional leading-zero blanking: define LED_SCAN_LEADING_ZERO_BLANK_EN.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEAD_CYC   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [4:0]            wr_data,
  input  logic                  commit,
  output logic [7:0]            seg_ABCDEFG_DP,
  output logic [NUM_DIGITS-1:0] digit_an,
  output logic                  frame_done,
  output logic                  commit_ack
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int CMAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
  localparam int CW   = $clog2(CMAX);
  localparam logic [IW-1:0]         LAST     = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0]         DEAD_END = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0]         DRV_END  = CW'(SCAN_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  logic [NUM_DIGITS-1:0][4:0] shadow, active;
  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic            pending;
  logic            wr_ok, boundary;
  logic [7:0]      dec_seg, drv_seg;

  assign wr_ok    = wr_en && (int'({29'd0, wr_addr}) < NUM_DIGITS);
  // Last cycle of the last digit's drive window; the copy lands on its closing edge.
  assign boundary = en && (state == DRIVE) && (cnt == DRV_END) && (idx == LAST);

  led_hex_decode u_dec (
    .digit (active[idx]),
    .seg   (dec_seg)
  );

`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
  logic lz_blank;
  always_comb begin
    lz_blank = (idx != '0);
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j >= int'(idx) && active[j] != 5'h00) lz_blank = 1'b0;
  end
  assign drv_seg = lz_blank ? SEG_OFF : dec_seg;
`else
  assign drv_seg = dec_seg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BLANK;
      idx            <= '0;
      cnt            <= '0;
      pending        <= 1'b0;
      shadow         <= '0;
      active         <= '0;
      seg_ABCDEFG_DP <= SEG_OFF;
      digit_an       <= '1;
      frame_done     <= 1'b0;
      commit_ack     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      commit_ack <= 1'b0;
      if (wr_ok) shadow[wr_addr[IW-1:0]] <= wr_data;

      // A commit arriving on the boundary itself waits for the following frame.
      if (boundary)    pending <= commit;
      else if (commit) pending <= 1'b1;

      if (!en) begin
        state          <= BLANK;
        idx            <= '0;
        cnt            <= '0;
        seg_ABCDEFG_DP <= SEG_OFF;
        digit_an       <= '1;
      end else begin
        case (state)
          BLANK: begin
            if (cnt == DEAD_END) begin
              state          <= DRIVE;
              cnt            <= '0;
              seg_ABCDEFG_DP <= drv_seg;
              digit_an       <= ~(AN_ONE << idx);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DRIVE: begin
            if (cnt == DRV_END) begin
              state          <= BLANK;
              cnt            <= '0;
              seg_ABCDEFG_DP <= SEG_OFF;
              digit_an       <= '1;
              if (idx == LAST) begin
                idx        <= '0;
                frame_done <= 1'b1;
                if (pending) begin
                  active     <= shadow;
                  commit_ack <= 1'b1;
                end
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= BLANK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Scoreboard bench for led_scan_ctrl (4 digits, 8-cycle drive, 2-cycle blanking).
module tb_led_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int DC = 2;
  localparam int SLOT = SD + DC;
  localparam int FL = ND * SLOT;

  localparam logic [7:0] GLYPH_T [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic       fd;
    logic       ack;
  } obs_t;

  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, wr_en = 1'b0, commit = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame_done, commit_ack;

  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];

  led_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .commit         (commit),
    .seg_ABCDEFG_DP (seg),
    .digit_an       (an),
    .frame_done     (frame_done),
    .commit_ack     (commit_ack)
  );

  always #5 clk = ~clk;

  // Expected outputs t cycles after en was first seen high (t=0 is that cycle).
  function automatic obs_t model(int t, logic [3:0][4:0] act, bit ack_due);
    obs_t       o;
    logic [3:0] one = 4'b0001;
    int p  = t % FL;
    int d  = p / SLOT;
    int ph = p % SLOT;
    o.seg = 8'hFF;
    o.an  = 4'hF;
    o.fd  = (t > 0) && (p == 0);
    o.ack = o.fd && ack_due;
    if (ph >= DC) begin
      o.an  = ~(one << d);
      o.seg = GLYPH_T[act[d][3:0]] & {7'h7F, ~act[d][4]};
`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
      if (d > 0) begin
        bit z = 1'b1;
        for (int j = d; j < ND; j++) if (act[j] != 5'h00) z = 1'b0;
        if (z) o.seg = 8'hFF;
      end
`endif
    end
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = {seg, an, frame_done, commit_ack};
    return o;
  endfunction

  task automatic test_reset();
    obs_t a, e;
    e = {8'hFF, 4'hF, 1'b0, 1'b0};
    repeat (2) begin
      sb.push_back(e);
      @(negedge clk);
      a = sample(); e = sb.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset: got seg=%h an=%b fd=%b ack=%b want seg=%h an=%b fd=%b ack=%b",
                 a.seg, a.an, a.fd, a.ack, e.seg, e.an, e.fd, e.ack);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back({8'hFF, 4'hF, 1'b0, 1'b0});
    @(negedge clk);
    a = sample(); e = sb.pop_front(); checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL idle_en_low: got seg=%h an=%b fd=%b ack=%b want seg=%h an=%b fd=%b ack=%b",
               a.seg, a.an, a.fd, a.ack, e.seg, e.an, e.fd, e.ack);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_default_scan();
    obs_t a, e;
    en = 1'b1;
    for (int t = 0; t < 2 * FL; t++) begin
      sb.push_back(model(t, '0, 1'b0));
      @(negedge clk);
      a = sample(); e = sb.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL default_scan t=%0d: got seg=%h an=%b fd=%b ack=%b want seg=%h an=%b fd=%b ack=%b",
                 t, a.seg, a.an, a.fd, a.ack, e.seg, e.an, e.fd, e.ack);
      end
      @(posedge clk); #1;
    end
  endtask

  // Writes 1..4 then two commits that must merge into one copy at t=120.
  task automatic test_commit();
    obs_t a, e;
    logic [3:0][4:0] act;
    for (int t = 2 * FL; t < 4 * FL; t++) begin
      wr_en = 1'b0; commit = 1'b0;
      if (t < 2 * FL + 4) begin
        wr_en = 1'b1; wr_addr = 3'(t - 2 * FL); wr_data = 5'(t - 2 * FL + 1);
      end
      if (t == 84 || t == 90) commit = 1'b1;
      act = (t < 3 * FL) ? '0 : {5'd4, 5'd3, 5'd2, 5'd1};
      sb.push_back(model(t, act, t == 3 * FL));
      @(negedge clk);
      a = sample(); e = sb.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL commit t=%0d: got seg=%h an=%b fd=%b ack=%b want seg=%h an=%b fd=%b ack=%b",
                 t, a.seg, a.an, a.fd, a.ack, e.seg, e.an, e.fd, e.ack);
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0; commit = 1'b0;
  endtask

  // Write in the boundary cycle, then a commit in the boundary cycle itself.
  task automatic test_boundary_write();
    obs_t a, e;
    logic [3:0][4:0] act;
    for (int t = 4 * FL; t < 8 * FL; t++) begin
      wr_en = 1'b0; commit = 1'b0;
      if (t == 165 || t == 239) commit = 1'b1;
      if (t == 199) begin wr_en = 1'b1; wr_addr = 3'd2; wr_data = 5'd5; end
      act = (t < 7 * FL) ? {5'd4, 5'd3, 5'd2, 5'd1} : {5'd4, 5'd5, 5'd2, 5'd1};
      sb.push_back(model(t, act, t == 5 * FL || t == 7 * FL));
      @(negedge clk);
      a = sample(); e = sb.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL boundary_write t=%0d: got seg=%h an=%b fd=%b ack=%b want seg=%h an=%b fd=%b ack=%b",
                 t, a.seg, a.an, a.fd, a.ack, e.seg, e.an, e.fd, e.ack);
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0; commit = 1'b0;
  endtask

  // en dropped for 3 cycles during digit 2 with a commit pending.
  task automatic test_en_low();
    obs_t a, e;
    localparam int BASE = 348;
    for (int t = 8 * FL; t < BASE + 2 * FL + 2; t++) begin
      wr_en = 1'b0; commit = 1'b0;
      en = !(t >= 345 && t < BASE);
      if (t == 321) begin wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'd9; end
      if (t == 322) commit = 1'b1;
      if (t <= 345)
        e = model(t, {5'd4, 5'd5, 5'd2, 5'd1}, 1'b0);
      else if (t < BASE)
        e = {8'hFF, 4'hF, 1'b0, 1'b0};
      else
        e = model(t - BASE, (t - BASE < FL) ? {5'd4, 5'd5, 5'd2, 5'd1} : {5'd4, 5'd5, 5'd2, 5'd9},
                  t - BASE == FL);
      sb.push_back(e);
      @(negedge clk);
      a = sample(); e = sb.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL en_low t=%0d: got seg=%h an=%b fd=%b ack=%b want seg=%h an=%b fd=%b ack=%b",
                 t, a.seg, a.an, a.fd, a.ack, e.seg, e.an, e.fd, e.ack);
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0; commit = 1'b0; en = 1'b1;
  endtask

  // Asynchronous reset mid-frame, then out-of-range write and leading-zero pattern.
  task automatic test_reset_midframe();
    obs_t a, e;
    logic [3:0][4:0] act;
    for (int t = 2 * FL + 2; t < 2 * FL + 22; t++) begin
      sb.push_back(model(t, {5'd4, 5'd5, 5'd2, 5'd9}, 1'b0));
      @(negedge clk);
      a = sample(); e = sb.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL pre_reset t=%0d: got seg=%h an=%b fd=%b ack=%b want seg=%h an=%b fd=%b ack=%b",
                 t, a.seg, a.an, a.fd, a.ack, e.seg, e.an, e.fd, e.ack);
      end
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    #1;
    sb.push_back({8'hFF, 4'hF, 1'b0, 1'b0});
    a = sample(); e = sb.pop_front(); checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL async_reset: got seg=%h an=%b fd=%b ack=%b want seg=%h an=%b fd=%b ack=%b",
               a.seg, a.an, a.fd, a.ack, e.seg, e.an, e.fd, e.ack);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int t = 0; t < 2 * FL + 2; t++) begin
      wr_en = 1'b0; commit = 1'b0;
      if (t == 1) begin wr_en = 1'b1; wr_addr = 3'd1; wr_data = 5'd7; end
      if (t == 2) begin wr_en = 1'b1; wr_addr = 3'd5; wr_data = 5'd3; end
      if (t == 3) commit = 1'b1;
      act = (t < FL) ? '0 : {5'd0, 5'd0, 5'd7, 5'd0};
      sb.push_back(model(t, act, t == FL));
      @(negedge clk);
      a = sample(); e = sb.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL post_reset t=%0d: got seg=%h an=%b fd=%b ack=%b want seg=%h an=%b fd=%b ack=%b",
                 t, a.seg, a.an, a.fd, a.ack, e.seg, e.an, e.fd, e.ack);
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0; commit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_scan();
    test_commit();
    test_boundary_write();
    test_en_low();
    test_reset_midframe();
    en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter SCAN_DIV, default 1000: clk cycles each digit is driven, at least 2.
REQ-003 Parameter DEAD_CYC, default 4: blanking cycles before each digit, at least 1.
REQ-004 clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 en  in  1  scan enable; low forces blanking.
REQ-007 wr_en  in  1  one-cycle write strobe into the shadow buffer.
REQ-008 wr_addr  in  3  digit index to write.
REQ-009 wr_data  in  5  {dp, hex[3:0]} for the addressed digit.
REQ-010 commit  in  1  one-cycle request to copy shadow to active at the next frame boundary.
REQ-011 seg_ABCDEFG_DP  out  8  segment drive, active-low; bit7 = A through bit1 = G, bit0 = DP.
REQ-012 digit_an  out  NUM_DIGITS  digit anode enables, active-low; bit i selects digit i.
REQ-013 frame_done  out  1  one-cycle pulse after the last digit's drive window.
REQ-014 commit_ack  out  1  one-cycle pulse in the cycle the active buffer updates.

Function
REQ-015 FSM states: BLANK and DRIVE.
REQ-016 BLANK lasts DEAD_CYC cycles with digit_an all 1 and seg_ABCDEFG_DP = 8'hFF.
REQ-017 DRIVE lasts SCAN_DIV cycles.
  - digit_an has only bit idx low.
  - seg_ABCDEFG_DP is the registered decode of active[idx].
REQ-018 Outputs are registered.
  - Segment and anode changes take effect together, in the first cycle of the state.
  - Segments and anodes never change within a state.
REQ-019 Leaving DRIVE:
  - idx increments.
  - If idx = NUM_DIGITS-1, idx wraps to 0 and frame_done pulses in the first cycle of the following BLANK.
REQ-020 Frame length is NUM_DIGITS*(DEAD_CYC+SCAN_DIV) cycles.
REQ-021 wr_en updates shadow[wr_addr] on the next edge.
  - wr_addr >= NUM_DIGITS is ignored.
  - Shadow writes never alter the display directly.
REQ-022 commit sets a pending flag.
  - At the frame boundary (the same cycle frame_done pulses), pending copies shadow to active, pulses commit_ack and clears pending.
  - Repeated commits before the boundary merge into one copy.
REQ-023 A write and the boundary in the same cycle:
  - The copy takes the shadow contents before the write.
  - The write is kept in shadow for the next commit.
REQ-024 commit in the same cycle as the boundary is not taken by that boundary; it stays pending for the next one.
REQ-025 en low:
  - Within one cycle the FSM enters BLANK, idx goes to 0 and the divider clears.
  - No frame_done or commit_ack is issued while en is low.
  - Pending commits are retained.
REQ-026 en rising starts a fresh frame at BLANK, digit 0.
REQ-027 Hex decode: 0-F use the standard seven-segment glyphs; dp=1 drives bit0 low.

Reset
REQ-028 When rst_n is low, all of the following hold and stay held while rst_n is low:
  - seg_ABCDEFG_DP = 8'hFF, digit_an all 1.
  - frame_done = 0, commit_ack = 0.
  - state = BLANK, idx = 0, counter = 0, pending = 0.
  - shadow and active all 5'h00.
REQ-029 Reset in mid-frame aborts the frame with no pulses issued.
  - After release, scan restarts at BLANK, digit 0.

Configuration
REQ-030 Macro LED_SCAN_LEADING_ZERO_BLANK_EN defined:
  - During DRIVE, a digit shows blank (8'hFF) when its active value is hex 0 with dp 0 and every higher-index digit is also hex 0 with dp 0.
  - Digit 0 is never blanked.
REQ-031 Macro undefined: every digit always shows its decoded value.

Structure
REQ-032 Package led_pkg holds:
  - the state enum (BLANK, DRIVE);
  - the 16-entry active-low glyph constant table;
  - the constant SEG_OFF = 8'hFF.
REQ-033 One sub-module, led_hex_decode: a combinational {dp, hex} to 8-bit active-low segment decoder, instantiated once on the selected digit.

Verification (NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYC=2)
REQ-034 Reset, then en=1 with no writes:
  - Expected 2 blank cycles, then digit_an = 4'b1110 for 8 cycles with seg = 8'h03 (glyph 0).
  - frame_done every 40 cycles.
REQ-035 Write addr0..3 = 1, 2, 3, 4, then commit:
  - No display change before the boundary.
  - commit_ack coincides with frame_done.
  - Next frame shows 8'h9F, 8'h25, 8'h0D, 8'h99 on anodes 1110, 1101, 1011, 0111.
REQ-036 wr_en to addr 2 with value 5 in the boundary cycle of a pending commit:
  - Active digit 2 keeps its old value.
  - Shadow[2] = 5 appears only after the next commit.
REQ-037 en low for 3 cycles mid-DRIVE of digit 2:
  - Blank output during the low cycles.
  - On restart, digit 0 is driven after 2 blank cycles.
  - No frame_done while en is low.
  - A pending commit still completes at the next boundary.
REQ-038 rst_n low in mid-frame:
  - Outputs go to 8'hFF / 4'b1111 without waiting for a clk edge.
  - Buffers are cleared.
  - wr_addr = 5 after reset is ignored.
REQ-039 With LED_SCAN_LEADING_ZERO_BLANK_EN and active = {0, 0, 7, 0} for digits 3..0:
  - Digits 3 and 2 are blank.
  - Digit 1 shows 8'h1F.
  - Digit 0 shows 8'h03.
